// File: rtl/modclk_phase_sweep_ctrl_if.sv
// Sweep configuration/request inputs and generator/readout outputs of the phase sweep controller.
// master drives START/ABORT/CFG_*, slave (the controller) drives the select lines and step status.
interface modclk_phase_sweep_ctrl_if #(
  parameter int DWELL_W = 16
);
  logic               START;
  logic               ABORT;
  logic [2:0]         CFG_FREQ_SEL;
  logic [3:0]         CFG_DUTY_SEL;
  logic [4:0]         CFG_PHASE_START;
  logic [4:0]         CFG_PHASE_STEP;
  logic [4:0]         CFG_NUM_STEPS;
  logic [DWELL_W-1:0] CFG_DWELL;
  logic [2:0]         FREQ_SEL;
  logic [4:0]         PHASE_SEL;
  logic [3:0]         DUTY_SEL;
  logic               BUSY;
  logic               STEP_STROBE;
  logic [4:0]         STEP_IDX;
  logic               DONE;

  modport master (
    output START, ABORT, CFG_FREQ_SEL, CFG_DUTY_SEL, CFG_PHASE_START,
           CFG_PHASE_STEP, CFG_NUM_STEPS, CFG_DWELL,
    input  FREQ_SEL, PHASE_SEL, DUTY_SEL, BUSY, STEP_STROBE, STEP_IDX, DONE
  );

  modport slave (
    input  START, ABORT, CFG_FREQ_SEL, CFG_DUTY_SEL, CFG_PHASE_START,
           CFG_PHASE_STEP, CFG_NUM_STEPS, CFG_DWELL,
    output FREQ_SEL, PHASE_SEL, DUTY_SEL, BUSY, STEP_STROBE, STEP_IDX, DONE
  );
endinterface

// File: rtl/modclk_phase_sweep_ctrl.sv
// Steps the modulation clock generator's PHASE_SEL through a programmed list, changing settings only on period boundaries; no backpressure.
// Latency START->first setting 1..L+1 cycles; MODCLK_SWEEP_LOOP_EN makes the sweep repeat until ABORT/RST.
module modclk_phase_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input logic                     CLK_IN,
  input logic                     RST,
  modclk_phase_sweep_ctrl_if.slave sweep
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SETTLE,
    S_DWELL,
    S_DONE
  } state_t;

  state_t             state;
  logic [3:0]         pcnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] sh_dwell;
  logic [2:0]         sh_freq;
  logic [3:0]         sh_duty;
  logic [4:0]         sh_phase_start;
  logic [4:0]         sh_phase_step;
  logic [4:0]         sh_last_idx;

  logic [2:0]         freq_sel;
  logic [4:0]         phase_sel;
  logic [3:0]         duty_sel;
  logic [4:0]         step_idx;
  logic               busy;
  logic               step_strobe;
  logic               done;

  logic               boundary;
  logic               arm_load;
  logic               short_nxt;
  logic               dwell_hit;
  logic               last_step;

  // The period reload must use the FREQ_SEL that will be driven after this edge.
  always_comb begin
    boundary  = (pcnt == 4'd0);
    arm_load  = (state == S_ARM) && boundary && !sweep.ABORT;
    short_nxt = arm_load ? sh_freq[1] : freq_sel[1];
    dwell_hit = ((dwell_cnt + DWELL_W'(1)) == sh_dwell);
    last_step = (step_idx == sh_last_idx);
  end

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state          <= S_IDLE;
      pcnt           <= 4'd15;
      dwell_cnt      <= '0;
      sh_dwell       <= '0;
      sh_freq        <= 3'd0;
      sh_duty        <= 4'd0;
      sh_phase_start <= 5'd0;
      sh_phase_step  <= 5'd0;
      sh_last_idx    <= 5'd0;
      freq_sel       <= 3'd0;
      phase_sel      <= 5'd0;
      duty_sel       <= 4'd0;
      step_idx       <= 5'd0;
      busy           <= 1'b0;
      step_strobe    <= 1'b0;
      done           <= 1'b0;
    end else begin
      pcnt        <= boundary ? (short_nxt ? 4'd7 : 4'd15) : (pcnt - 4'd1);
      step_strobe <= 1'b0;
      done        <= 1'b0;

      if (sweep.ABORT) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (sweep.START) begin
              sh_freq        <= sweep.CFG_FREQ_SEL;
              sh_duty        <= sweep.CFG_DUTY_SEL;
              sh_phase_start <= sweep.CFG_PHASE_START;
              sh_phase_step  <= sweep.CFG_PHASE_STEP;
              sh_last_idx    <= (sweep.CFG_NUM_STEPS == 5'd0) ? 5'd0 : (sweep.CFG_NUM_STEPS - 5'd1);
              sh_dwell       <= (sweep.CFG_DWELL == '0) ? DWELL_W'(1) : sweep.CFG_DWELL;
              busy           <= 1'b1;
              state          <= S_ARM;
            end
          end
          S_ARM: begin
            if (boundary) begin
              freq_sel  <= sh_freq;
              duty_sel  <= sh_duty;
              phase_sel <= sh_phase_start;
              step_idx  <= 5'd0;
              state     <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (boundary) begin
              step_strobe <= 1'b1;
              dwell_cnt   <= '0;
              state       <= S_DWELL;
            end
          end
          S_DWELL: begin
            if (boundary) begin
              dwell_cnt <= dwell_cnt + DWELL_W'(1);
              if (dwell_hit) begin
                if (last_step) begin
                  done <= 1'b1;
`ifdef MODCLK_SWEEP_LOOP_EN
                  phase_sel <= sh_phase_start;
                  step_idx  <= 5'd0;
                  state     <= S_SETTLE;
`else
                  state     <= S_DONE;
`endif
                end else begin
                  phase_sel <= phase_sel + sh_phase_step;
                  step_idx  <= step_idx + 5'd1;
                  state     <= S_SETTLE;
                end
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign sweep.FREQ_SEL    = freq_sel;
  assign sweep.PHASE_SEL   = phase_sel;
  assign sweep.DUTY_SEL    = duty_sel;
  assign sweep.STEP_IDX    = step_idx;
  assign sweep.BUSY        = busy;
  assign sweep.STEP_STROBE = step_strobe;
  assign sweep.DONE        = done;

endmodule
